// File: rtl/relu_offset_sched.sv
// ============================================================================
// Module      : relu_offset_sched
// Description : Round-robin scheduler sharing one ReLU(x+offset) float32
//               datapath between NREQ requesters with per-requester offsets.
//               Tracks in-flight beats with a tag FIFO and routes results
//               back to the issuing requester.
//               Optional macro RELU_OFFSET_SCHED_ERRCHK_EN enables a sticky
//               error flag for datapath results arriving with no beat in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module relu_offset_sched #(
  parameter int NREQ         = 2,
  parameter int LAT          = 3,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*256-1:0]   req_data,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [255:0]          rsp_data,
  input  logic                  cfg_wr,
  input  logic [1:0]            cfg_sel,
  input  logic [31:0]           cfg_data,
  output logic                  dp_enable,
  output logic                  dp_src_valid,
  output logic [255:0]          dp_src,
  output logic [31:0]           dp_offset,
  input  logic                  dp_dst_valid,
  input  logic [255:0]          dp_dst,
  output logic                  err
);

  // Tag FIFO storage is rounded up to a power of two so pointers wrap freely;
  // the credit counter alone bounds occupancy to MAX_INFLIGHT.
  localparam int PW    = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int DEPTH = 1 << PW;
  localparam int CW    = $clog2(MAX_INFLIGHT + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  generate
    if (NREQ < 2 || NREQ > 4 || LAT < 1 || MAX_INFLIGHT < 1) begin : g_param_check
      $error("relu_offset_sched: parameter out of range");
    end
  endgenerate

  logic [0:0]    state;
  logic [1:0]    rr;
  logic [CW-1:0] inflight;
  logic [31:0]   off [NREQ];
  logic [1:0]    tag_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          any_valid;
  logic          found;
  logic          issue;
  logic          pop;
  logic [1:0]    grant_idx;
  logic [255:0]  grant_data;
  logic [31:0]   grant_off;

  // Position k of the round-robin search order starting at base.
  function automatic int rr_index(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return s;
  endfunction

  // Round-robin arbitration; a grant is only presented while a credit is free.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && rr_index(rr, k) == i) begin
          found     = 1'b1;
          grant_idx = 2'(i);
        end
      end
    end
    issue      = found && (state == S_RUN) && (inflight < CW'(MAX_INFLIGHT));
    grant_data = '0;
    grant_off  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = issue && (grant_idx == 2'(i));
      if (grant_idx == 2'(i)) begin
        grant_data = req_data[i*256 +: 256];
        grant_off  = off[i];
      end
    end
  end

  assign any_valid = |req_valid;
  // Results arriving with nothing in flight are dropped here.
  assign pop       = dp_dst_valid && (inflight != '0);
  assign dp_enable = (state == S_RUN);

  // Run/idle control and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rr    <= '0;
    end else begin
      case (state)
        S_IDLE:  if (any_valid) state <= S_RUN;
        S_RUN:   if (!any_valid && inflight == '0) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (issue) rr <= (grant_idx == 2'(NREQ - 1)) ? 2'd0 : grant_idx + 2'd1;
    end
  end

  // Per-requester offset registers; out-of-range selects match no entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) off[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (cfg_wr && cfg_sel == 2'(i)) off[i] <= cfg_data;
      end
    end
  end

  // Datapath source registers: offset sampled at issue so later writes do not
  // disturb beats already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_src_valid <= 1'b0;
      dp_src       <= '0;
      dp_offset    <= '0;
    end else begin
      dp_src_valid <= issue;
      if (issue) begin
        dp_src    <= grant_data;
        dp_offset <= grant_off;
      end
    end
  end

  // Tag FIFO and credit counter; a same-cycle issue and return cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
      for (int i = 0; i < DEPTH; i++) tag_mem[i] <= '0;
    end else begin
      if (issue) begin
        tag_mem[wr_ptr] <= grant_idx;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({issue, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Route each returned result to the requester recorded in its tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) rsp_valid[i] <= pop && (tag_mem[rd_ptr] == 2'(i));
      if (pop) rsp_data <= dp_dst;
    end
  end

`ifdef RELU_OFFSET_SCHED_ERRCHK_EN
  logic err_q;

  // Sticky flag for a datapath result with no matching in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (dp_dst_valid && inflight == '0) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire
